// File: rtl/pll_reconfig_sequencer.sv
// Avalon-MM master that retunes pll_0 through the pll_reconfig_0 mgmt slave.
// On a cfg_req rising edge: mode, N, M, C0, start writes, then status polling.
module pll_reconfig_sequencer #(
    parameter logic [71:0] N_TABLE    = 72'h0,
    parameter logic [71:0] M_TABLE    = 72'h0,
    parameter logic [71:0] C0_TABLE   = 72'h0,
    parameter int unsigned POLL_GAP   = 16,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        cfg_req,
    input  logic [1:0]  cfg_profile,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_read,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest
);

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 18;
    localparam int unsigned GAP_W  = $clog2(POLL_GAP + 1);
    localparam int unsigned POLL_W = $clog2(POLL_LIMIT + 1);

    localparam logic [ADDR_W-1:0] ADDR_MODE   = ADDR_W'(6'h00);
    localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(6'h01);
    localparam logic [ADDR_W-1:0] ADDR_START  = ADDR_W'(6'h02);
    localparam logic [ADDR_W-1:0] ADDR_N      = ADDR_W'(6'h03);
    localparam logic [ADDR_W-1:0] ADDR_M      = ADDR_W'(6'h04);
    localparam logic [ADDR_W-1:0] ADDR_C      = ADDR_W'(6'h05);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_N,
        ST_WR_M,
        ST_WR_C0,
        ST_WR_START,
        ST_GAP,
        ST_RD_STAT,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              read;
        logic              write;
    } mgmt_cmd_t;

    state_t            state_q, state_d;
    mgmt_cmd_t         cmd_q, cmd_d;
    logic [1:0]        prof_q, prof_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              req_q;
    logic              armed_q;
    logic              start;
    logic              xfer_ok;
    logic              unused_rd;

    // Status bit 0 is the only readdata bit the sequencer looks at.
    assign unused_rd = ^mgmt_readdata[DATA_W-1:1];

    // A level already high when reset releases is not an edge; req must drop first.
    assign start   = cfg_req & ~req_q & armed_q;
    assign xfer_ok = ~mgmt_waitrequest;

    function automatic logic [CNT_W-1:0] pick(input logic [71:0] tbl, input logic [1:0] p);
        logic [CNT_W-1:0] w;
        case (p)
            2'd0:    w = tbl[17:0];
            2'd1:    w = tbl[35:18];
            2'd2:    w = tbl[53:36];
            default: w = tbl[71:54];
        endcase
        return w;
    endfunction

    // State, profile and counter registers plus registered bus/status outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            prof_q  <= '0;
            poll_q  <= '0;
            gap_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            req_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            prof_q  <= prof_d;
            poll_q  <= poll_d;
            gap_q   <= gap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            req_q   <= cfg_req;
            armed_q <= armed_q | ~cfg_req;
        end
    end

    // Next state; outputs are decoded from the next state so each state is entered
    // with its strobe, address and data already valid.
    always_comb begin
        state_d = state_q;
        prof_d  = prof_q;
        poll_d  = poll_q;
        gap_d   = gap_q;
        cmd_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        error_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WR_MODE;
                    prof_d  = cfg_profile;
                    poll_d  = '0;
                end
            end
            ST_WR_MODE:  if (xfer_ok) state_d = ST_WR_N;
            ST_WR_N:     if (xfer_ok) state_d = ST_WR_M;
            ST_WR_M:     if (xfer_ok) state_d = ST_WR_C0;
            ST_WR_C0:    if (xfer_ok) state_d = ST_WR_START;
            ST_WR_START: begin
                if (xfer_ok) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(POLL_GAP - 1)) begin
                    state_d = ST_RD_STAT;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_RD_STAT: begin
                if (xfer_ok) begin
                    if (mgmt_readdata[0]) begin
                        state_d = ST_DONE;
                    end else begin
                        poll_d = poll_q + POLL_W'(1);
                        if (poll_d == POLL_W'(POLL_LIMIT)) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        unique case (state_d)
            ST_WR_MODE: begin
                cmd_d.addr  = ADDR_MODE;
                cmd_d.wdata = DATA_W'(1);
                cmd_d.write = 1'b1;
            end
            ST_WR_N: begin
                cmd_d.addr  = ADDR_N;
                cmd_d.wdata = {14'b0, pick(N_TABLE, prof_d)};
                cmd_d.write = 1'b1;
            end
            ST_WR_M: begin
                cmd_d.addr  = ADDR_M;
                cmd_d.wdata = {14'b0, pick(M_TABLE, prof_d)};
                cmd_d.write = 1'b1;
            end
            ST_WR_C0: begin
                cmd_d.addr  = ADDR_C;
                cmd_d.wdata = {9'b0, 5'd0, pick(C0_TABLE, prof_d)};
                cmd_d.write = 1'b1;
            end
            ST_WR_START: begin
                cmd_d.addr  = ADDR_START;
                cmd_d.write = 1'b1;
            end
            ST_RD_STAT: begin
                cmd_d.addr = ADDR_STATUS;
                cmd_d.read = 1'b1;
            end
            default: cmd_d = '0;
        endcase

        busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERR);
        done_d  = (state_d == ST_DONE);
        error_d = (state_d == ST_ERR);
    end

    assign cfg_busy       = busy_q;
    assign cfg_done       = done_q;
    assign cfg_error      = error_q;
    assign mgmt_address   = cmd_q.addr;
    assign mgmt_read      = cmd_q.read;
    assign mgmt_write     = cmd_q.write;
    assign mgmt_writedata = cmd_q.wdata;

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Scoreboard bench for pll_reconfig_sequencer: expected bus transfers are queued
// per scenario and checked by a negedge monitor acting as the mgmt slave.
module tb_pll_reconfig_sequencer;

    localparam int unsigned POLL_GAP   = 3;
    localparam int unsigned POLL_LIMIT = 4;

    localparam logic [17:0] N0 = 18'h00404, N1 = 18'h00808, N2 = 18'h10C0C, N3 = 18'h21010;
    localparam logic [17:0] M0 = 18'h00020, M1 = 18'h0002A, M2 = 18'h20030, M3 = 18'h00101;
    localparam logic [17:0] C0 = 18'h00202, C1 = 18'h20505, C2 = 18'h00306, C3 = 18'h3FFFF;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        cfg_req = 1'b0;
    logic [1:0]  cfg_profile = 2'd0;
    logic        cfg_busy, cfg_done, cfg_error;
    logic [5:0]  mgmt_address;
    logic        mgmt_read, mgmt_write;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = 32'hFFFF_FFFF;
    logic        mgmt_waitrequest = 1'b0;

    pll_reconfig_sequencer #(
        .N_TABLE   ({N3, N2, N1, N0}),
        .M_TABLE   ({M3, M2, M1, M0}),
        .C0_TABLE  ({C3, C2, C1, C0}),
        .POLL_GAP  (POLL_GAP),
        .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .cfg_req         (cfg_req),
        .cfg_profile     (cfg_profile),
        .cfg_busy        (cfg_busy),
        .cfg_done        (cfg_done),
        .cfg_error       (cfg_error),
        .mgmt_address    (mgmt_address),
        .mgmt_read       (mgmt_read),
        .mgmt_write      (mgmt_write),
        .mgmt_writedata  (mgmt_writedata),
        .mgmt_readdata   (mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct packed {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    int          rd_cyc[$];
    logic [17:0] n_val[4];
    logic [17:0] m_val[4];
    logic [17:0] c_val[4];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0;
    int wr_cnt = 0, rd_cnt = 0;
    int strobe_cyc = 0, addr4_cyc = 0;
    int done_on = 0;

    always @(posedge clk_clk) cyc <= cyc + 1;

    // Slave model and scoreboard: every strobed cycle is checked against the queue head.
    always @(negedge clk_clk) begin
        txn_t got;
        if (mgmt_read) mgmt_readdata = (rd_cnt + 1 == done_on) ? 32'h0000_0001 : 32'h0000_0000;
        else           mgmt_readdata = 32'hFFFF_FFFF;
        if (cfg_done)  done_cnt++;
        if (cfg_error) err_cnt++;
        if (cfg_done || cfg_error) begin
            n_cmp++;
            if (cfg_busy !== 1'b0 || (cfg_done && cfg_error)) begin
                n_bad++;
                $display("FAIL pulse_flags: busy=%0b done=%0b error=%0b, required busy=0 and one pulse",
                         cfg_busy, cfg_done, cfg_error);
            end
        end
        if (mgmt_read || mgmt_write) begin
            strobe_cyc++;
            if (mgmt_write && mgmt_address == 6'h04) addr4_cyc++;
            got = {mgmt_write, mgmt_address, (mgmt_write ? mgmt_writedata : 32'h0)};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_txn: got wr=%0b addr=%h data=%h, required no transfer",
                         got.wr, got.addr, got.data);
            end else if ((mgmt_read && mgmt_write) || got !== exp_q[0]) begin
                n_bad++;
                $display("FAIL bus_txn: got wr=%0b rd=%0b addr=%h data=%h, required wr=%0b addr=%h data=%h",
                         mgmt_write, mgmt_read, got.addr, got.data, exp_q[0].wr, exp_q[0].addr, exp_q[0].data);
            end
            if (!mgmt_waitrequest) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (mgmt_write) wr_cnt++;
                else begin
                    rd_cnt++;
                    rd_cyc.push_back(cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic push_writes(input int p);
        exp_q.push_back({1'b1, 6'h00, 32'h0000_0001});
        exp_q.push_back({1'b1, 6'h03, {14'b0, n_val[p]}});
        exp_q.push_back({1'b1, 6'h04, {14'b0, m_val[p]}});
        exp_q.push_back({1'b1, 6'h05, {9'b0, 5'd0, c_val[p]}});
        exp_q.push_back({1'b1, 6'h02, 32'h0});
    endtask

    task automatic push_reads(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 6'h01, 32'h0});
    endtask

    task automatic wait_end(input string name, input int budget);
        int d0 = done_cnt + err_cnt;
        int k = 0;
        while (done_cnt + err_cnt == d0 && k < budget) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (done_cnt + err_cnt == d0) begin
            n_bad++;
            $display("FAIL %s_end_timeout: no done/error within %0d cycles, required one", name, budget);
        end
    endtask

    task automatic wait_addr4(input string name);
        int k = 0;
        while (!(mgmt_write && mgmt_address == 6'h04) && k < 40) begin
            tick(1);
            k++;
        end
        n_cmp++;
        if (!(mgmt_write && mgmt_address == 6'h04)) begin
            n_bad++;
            $display("FAIL %s_no_wr_m: addr=%h write=%0b, required write to 04", name, mgmt_address, mgmt_write);
        end
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        cfg_req = 1'b0;
        mgmt_waitrequest = 1'b0;
        tick(3);
        n_cmp++;
        if ({cfg_busy, cfg_done, cfg_error} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_status: got %b, required 000", {cfg_busy, cfg_done, cfg_error});
        end
        n_cmp++;
        if ({mgmt_read, mgmt_write} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_strobes: got %b, required 00", {mgmt_read, mgmt_write});
        end
        n_cmp++;
        if (mgmt_address !== 6'h0 || mgmt_writedata !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_bus: addr=%h data=%h, required 0/0", mgmt_address, mgmt_writedata);
        end
        reset_reset_n = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        int d0 = done_cnt, e0 = err_cnt;
        rd_cnt = 0; wr_cnt = 0; done_on = 3;
        push_writes(1);
        push_reads(3);
        cfg_req = 1'b0;
        tick(2);
        cfg_profile = 2'd1;
        cfg_req = 1'b1;
        tick(1);
        n_cmp++;
        if (!(mgmt_write === 1'b1 && mgmt_address === 6'h00 && cfg_busy === 1'b1)) begin
            n_bad++;
            $display("FAIL basic_latency: write=%0b addr=%h busy=%0b, required 1/00/1",
                     mgmt_write, mgmt_address, cfg_busy);
        end
        cfg_req = 1'b0;
        wait_end("basic", 200);
        n_cmp++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            n_bad++;
            $display("FAIL basic_pulses: done=%0d error=%0d, required 1/0", done_cnt - d0, err_cnt - e0);
        end
        n_cmp++;
        if (wr_cnt != 5 || rd_cnt != 3 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL basic_counts: writes=%0d reads=%0d left=%0d, required 5/3/0", wr_cnt, rd_cnt, exp_q.size());
        end
        n_cmp++;
        if (cfg_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_busy_after: got %0b, required 0", cfg_busy);
        end
    endtask

    task automatic test_stall();
        int d0 = done_cnt;
        rd_cnt = 0; wr_cnt = 0; done_on = 1; addr4_cyc = 0;
        push_writes(1);
        push_reads(1);
        cfg_req = 1'b0;
        tick(2);
        cfg_profile = 2'd1;
        cfg_req = 1'b1;
        tick(1);
        cfg_req = 1'b0;
        wait_addr4("stall");
        mgmt_waitrequest = 1'b1;
        tick(5);
        mgmt_waitrequest = 1'b0;
        tick(1);
        n_cmp++;
        if (!(mgmt_write === 1'b1 && mgmt_address === 6'h05)) begin
            n_bad++;
            $display("FAIL stall_next: write=%0b addr=%h, required 1/05", mgmt_write, mgmt_address);
        end
        wait_end("stall", 200);
        n_cmp++;
        if (addr4_cyc != 6) begin
            n_bad++;
            $display("FAIL stall_wr_m_cycles: got %0d, required 6", addr4_cyc);
        end
        n_cmp++;
        if (wr_cnt != 5 || exp_q.size() != 0 || done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL stall_counts: writes=%0d left=%0d done=%0d, required 5/0/1",
                     wr_cnt, exp_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt, e0 = err_cnt, s0;
        rd_cnt = 0; wr_cnt = 0; done_on = 0;
        rd_cyc.delete();
        push_writes(0);
        push_reads(POLL_LIMIT);
        cfg_req = 1'b0;
        tick(2);
        cfg_profile = 2'd0;
        cfg_req = 1'b1;
        tick(1);
        cfg_req = 1'b0;
        wait_end("timeout", 300);
        n_cmp++;
        if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
            n_bad++;
            $display("FAIL timeout_pulses: error=%0d done=%0d, required 1/0", err_cnt - e0, done_cnt - d0);
        end
        n_cmp++;
        if (rd_cnt != POLL_LIMIT || rd_cyc.size() != POLL_LIMIT) begin
            n_bad++;
            $display("FAIL timeout_reads: got %0d, required %0d", rd_cnt, POLL_LIMIT);
        end
        for (int i = 1; i < rd_cyc.size(); i++) begin
            n_cmp++;
            if (rd_cyc[i] - rd_cyc[i-1] != POLL_GAP + 1) begin
                n_bad++;
                $display("FAIL timeout_spacing%0d: got %0d cycles, required %0d", i,
                         rd_cyc[i] - rd_cyc[i-1], POLL_GAP + 1);
            end
        end
        s0 = strobe_cyc;
        tick(10);
        n_cmp++;
        if (strobe_cyc != s0 || cfg_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_idle: strobes=%0d busy=%0b, required 0/0", strobe_cyc - s0, cfg_busy);
        end
    endtask

    task automatic test_ignore_busy();
        int d0 = done_cnt, s0;
        rd_cnt = 0; wr_cnt = 0; done_on = 2;
        push_writes(1);
        push_reads(2);
        cfg_req = 1'b0;
        tick(2);
        cfg_profile = 2'd1;
        cfg_req = 1'b1;
        tick(1);
        cfg_req = 1'b0;
        tick(1);
        cfg_profile = 2'd2;
        cfg_req = 1'b1;
        tick(1);
        cfg_req = 1'b0;
        wait_end("ignore", 200);
        n_cmp++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0 || wr_cnt != 5) begin
            n_bad++;
            $display("FAIL ignore_first: done=%0d left=%0d writes=%0d, required 1/0/5",
                     done_cnt - d0, exp_q.size(), wr_cnt);
        end
        s0 = strobe_cyc;
        tick(10);
        n_cmp++;
        if (strobe_cyc != s0) begin
            n_bad++;
            $display("FAIL ignore_queued: strobes=%0d, required 0", strobe_cyc - s0);
        end
        rd_cnt = 0; wr_cnt = 0;
        push_writes(2);
        push_reads(2);
        cfg_req = 1'b1;
        tick(1);
        cfg_req = 1'b0;
        wait_end("profile2", 200);
        n_cmp++;
        if (done_cnt - d0 != 2 || exp_q.size() != 0 || wr_cnt != 5) begin
            n_bad++;
            $display("FAIL profile2_seq: done=%0d left=%0d writes=%0d, required 2/0/5",
                     done_cnt - d0, exp_q.size(), wr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int d0, s0;
        rd_cnt = 0; wr_cnt = 0; done_on = 1;
        push_writes(3);
        cfg_req = 1'b0;
        tick(2);
        cfg_profile = 2'd3;
        cfg_req = 1'b1;
        tick(1);
        wait_addr4("rstmid");
        mgmt_waitrequest = 1'b1;
        tick(2);
        #2;
        reset_reset_n = 1'b0;
        #1;
        n_cmp++;
        if (mgmt_write !== 1'b0 || cfg_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_async: write=%0b busy=%0b, required 0/0", mgmt_write, cfg_busy);
        end
        exp_q.delete();
        tick(2);
        mgmt_waitrequest = 1'b0;
        reset_reset_n = 1'b1;
        s0 = strobe_cyc;
        tick(50);
        n_cmp++;
        if (strobe_cyc != s0 || cfg_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_held_req: strobes=%0d busy=%0b, required 0/0", strobe_cyc - s0, cfg_busy);
        end
        cfg_req = 1'b0;
        tick(1);
        d0 = done_cnt;
        rd_cnt = 0; wr_cnt = 0;
        push_writes(3);
        push_reads(1);
        cfg_req = 1'b1;
        tick(1);
        cfg_req = 1'b0;
        wait_end("rstmid", 200);
        n_cmp++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0 || wr_cnt != 5) begin
            n_bad++;
            $display("FAIL rstmid_restart: done=%0d left=%0d writes=%0d, required 1/0/5",
                     done_cnt - d0, exp_q.size(), wr_cnt);
        end
    endtask

    task automatic test_level_hold();
        int d0 = done_cnt, e0 = err_cnt;
        rd_cnt = 0; wr_cnt = 0; done_on = 1;
        cfg_req = 1'b0;
        tick(2);
        push_writes(0);
        push_reads(1);
        cfg_profile = 2'd0;
        cfg_req = 1'b1;
        tick(2000);
        cfg_req = 1'b0;
        tick(2);
        n_cmp++;
        if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
            n_bad++;
            $display("FAIL level_pulses: done=%0d error=%0d, required 1/0", done_cnt - d0, err_cnt - e0);
        end
        n_cmp++;
        if (wr_cnt != 5 || rd_cnt != 1 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL level_counts: writes=%0d reads=%0d left=%0d, required 5/1/0",
                     wr_cnt, rd_cnt, exp_q.size());
        end
    endtask

    initial begin
        n_val[0] = N0; n_val[1] = N1; n_val[2] = N2; n_val[3] = N3;
        m_val[0] = M0; m_val[1] = M1; m_val[2] = M2; m_val[3] = M3;
        c_val[0] = C0; c_val[1] = C1; c_val[2] = C2; c_val[3] = C3;
        test_reset();
        test_basic();
        test_stall();
        test_timeout();
        test_ignore_busy();
        test_reset_mid();
        test_level_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
